genetic_top: RTL and testbench
==============================

GENETIC_TOP -- requirements
Module: genetic_top

Interface
REQ-001 Parameter GENOME_LENGTH, default 28, genes (bytes) per chromosome; SHALL be 2..31.
REQ-002 Parameter POP_SIZE, default 10, entries in fitness_array; SHALL be at least 2.
REQ-003 Parameter WIDTH, default 5, bits per fitness_array entry.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse launching a run.
REQ-007 chromosome  input  [7:0] x GENOME_LENGTH  candidate string.
REQ-008 target  input  [7:0] x GENOME_LENGTH  reference string.
REQ-009 parent1, parent2  input  [7:0] x GENOME_LENGTH  mating parents.
REQ-010 fitness_array  input  [WIDTH-1:0] x POP_SIZE  population fitness values to sort.
REQ-011 fitness  output  5  count of positions where chromosome equals target.
REQ-012 sorted_array  output  [WIDTH-1:0] x POP_SIZE  fitness_array sorted in descending order, index 0 highest.
REQ-013 child  output  [7:0] x GENOME_LENGTH  crossover (and optional mutation) result.
REQ-014 done_fit, done_sort, done_mate  output  1 each  sticky phase-complete flags.

Function
REQ-015 FSM states: IDLE, FIT, SORT, MATE, DONE; phases run strictly sequentially.
REQ-016 In IDLE or DONE, start=1 SHALL capture all array inputs into internal registers, clear fitness, child and all done flags, and enter FIT.
REQ-017 Inputs SHALL be sampled only at start; later input changes SHALL NOT affect the run.
REQ-018 A start pulse in FIT, SORT or MATE SHALL be ignored.
REQ-019 Edge 0 is the edge that samples start; FIT SHALL compare gene k-1 at edge k (k=1..GENOME_LENGTH) and increment fitness on an 8-bit equality match.
REQ-020 done_fit SHALL rise at edge GENOME_LENGTH, at which fitness is final; 28 cycles by default.
REQ-021 SORT SHALL perform POP_SIZE odd-even transposition passes, one per cycle, alternating even and odd pair sets; swap when the lower-indexed element is smaller (unsigned).
REQ-022 done_sort SHALL rise at edge GENOME_LENGTH+POP_SIZE (default 38); duplicate values SHALL be preserved.
REQ-023 MATE SHALL write one gene per cycle: child[i] = parent1[i] for i < GENOME_LENGTH/2 (integer division), else parent2[i].
REQ-024 done_mate SHALL rise at edge 2*GENOME_LENGTH+POP_SIZE (default 66), then FSM enters DONE.
REQ-025 All done flags SHALL remain high until the next accepted start or rst.
REQ-026 sorted_array SHALL expose the working sort register; it is valid only while done_sort=1.

Reset
REQ-027 rst=1 SHALL force IDLE and zero fitness, sorted_array, child, all done flags and all captured registers.
REQ-028 rst SHALL take priority over start; reset mid-phase SHALL abort the run with no partial result retained.
REQ-029 The mutation LFSR SHALL reset to 8'hA5.

Configuration
REQ-030 Macro GENETIC_MUTATION_EN: when defined, an 8-bit maximal-length LFSR (taps 8,6,5,4) SHALL advance once per MATE cycle.
REQ-031 When GENETIC_MUTATION_EN is defined and lfsr[3:0]==0, the gene written that cycle SHALL be replaced by 8'd97+lfsr[7:4].
REQ-032 When GENETIC_MUTATION_EN is undefined, child SHALL be pure crossover and the LFSR SHALL be absent.

Structure
REQ-033 Package genetic_pkg SHALL hold the FSM state enum, the LFSR seed and tap constants, and the mutation base constant 8'd97.
REQ-034 The odd-even sort network SHALL be a sub-module ga_sorter (parameters POP_SIZE and WIDTH; ports load, step, done); fitness and mate logic remain in genetic_top.

Verification
REQ-035 chromosome==target (all 28 genes) -> fitness=28; done_fit rises exactly 28 cycles after start.
REQ-036 chromosome differs from target at every gene -> fitness=0; done_fit still at cycle 28.
REQ-037 fitness_array={0,1,...,9} -> sorted_array={9,...,0} at cycle 38; input {3,3,7,0,...} -> duplicate 3s retained.
REQ-038 GENETIC_MUTATION_EN undefined, parent1 all 'a', parent2 all 'z' -> child = 14 'a' followed by 14 'z'; done_mate at cycle 66.
REQ-039 rst asserted during SORT -> next cycle all outputs 0 and state IDLE; a new start completes with the same 28/38/66 timing.
REQ-040 start pulsed during MATE -> ignored and timing unchanged; start in DONE -> done flags clear and a fresh run begins.

Source files
------------

// File: rtl/genetic_pkg.sv
// Shared types and constants for the genetic-algorithm engine.
// The optional mutation stage is enabled with the GENETIC_MUTATION_EN macro.
package genetic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FIT  = 3'd1,
        ST_SORT = 3'd2,
        ST_MATE = 3'd3,
        ST_DONE = 3'd4
    } ga_state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1 map onto bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] MUT_BASE  = 8'd97;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ga_sorter.sv
// Odd-even transposition sorter: descending order, one pass per step,
// done rises on the same edge that applies the final pass.
module ga_sorter
    import genetic_pkg::*;
#(
    parameter int POP_SIZE = 10,
    parameter int WIDTH    = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic                             step,
    input  logic [POP_SIZE-1:0][WIDTH-1:0]   data_in,
    output logic [POP_SIZE-1:0][WIDTH-1:0]   data_out,
    output logic                             done
);

    localparam int PW = $clog2(POP_SIZE + 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(POP_SIZE - 1);

    logic [POP_SIZE-1:0][WIDTH-1:0] arr_q, arr_d;
    logic [PW-1:0]                  pass_q, pass_d;
    logic                           done_q, done_d;
    logic [POP_SIZE-2:0]            swap_s;

    // Pair selection: even passes start at index 0, odd passes at index 1.
    always_comb begin
        swap_s = '0;
        for (int i = 0; i < POP_SIZE - 1; i++) begin
            swap_s[i] = (1'(i) == pass_q[0]) && (arr_q[i] < arr_q[i+1]);
        end
    end

    // Next-state for the working array, pass counter and done flag.
    always_comb begin
        arr_d  = arr_q;
        pass_d = pass_q;
        done_d = done_q;
        if (load) begin
            arr_d  = data_in;
            pass_d = '0;
            done_d = 1'b0;
        end else if (step && !done_q) begin
            for (int i = 0; i < POP_SIZE - 1; i++) begin
                arr_d[i]   = swap_s[i] ? arr_q[i+1] : arr_d[i];
                arr_d[i+1] = swap_s[i] ? arr_q[i]   : arr_d[i+1];
            end
            pass_d = pass_q + PW'(1);
            if (pass_q == LAST_PASS) begin
                done_d = 1'b1;
            end else begin
                done_d = 1'b0;
            end
        end else begin
            arr_d  = arr_q;
        end
    end

    // Sorter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            arr_q  <= '0;
            pass_q <= '0;
            done_q <= 1'b0;
        end else begin
            arr_q  <= arr_d;
            pass_q <= pass_d;
            done_q <= done_d;
        end
    end

    assign data_out = arr_q;
    assign done     = done_q;

endmodule

// File: rtl/genetic_top.sv
// Sequential GA engine: fitness count, population sort, crossover child.
// Define GENETIC_MUTATION_EN to add LFSR-driven gene mutation during MATE.
module genetic_top
    import genetic_pkg::*;
#(
    parameter int GENOME_LENGTH = 28,
    parameter int POP_SIZE      = 10,
    parameter int WIDTH         = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [GENOME_LENGTH-1:0][7:0]       chromosome,
    input  logic [GENOME_LENGTH-1:0][7:0]       target,
    input  logic [GENOME_LENGTH-1:0][7:0]       parent1,
    input  logic [GENOME_LENGTH-1:0][7:0]       parent2,
    input  logic [POP_SIZE-1:0][WIDTH-1:0]      fitness_array,
    output logic [4:0]                          fitness,
    output logic [POP_SIZE-1:0][WIDTH-1:0]      sorted_array,
    output logic [GENOME_LENGTH-1:0][7:0]       child,
    output logic                                done_fit,
    output logic                                done_sort,
    output logic                                done_mate
);

    localparam int IDX_W = 16;
    localparam int GI_W  = $clog2(GENOME_LENGTH);
    localparam logic [IDX_W-1:0] LAST_GENE = IDX_W'(GENOME_LENGTH - 1);
    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(POP_SIZE - 1);
    localparam logic [GI_W-1:0]  HALF      = GI_W'(GENOME_LENGTH / 2);

    ga_state_e state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [GENOME_LENGTH-1:0][7:0]     chrom_q, chrom_d;
    logic [GENOME_LENGTH-1:0][7:0]     target_q, target_d;
    logic [GENOME_LENGTH-1:0][7:0]     p1_q, p1_d;
    logic [GENOME_LENGTH-1:0][7:0]     p2_q, p2_d;
    logic [GENOME_LENGTH-1:0][7:0]     child_q, child_d;
    logic [4:0]                        fitness_q, fitness_d;
    logic                              done_fit_q, done_fit_d;
    logic                              done_mate_q, done_mate_d;
    logic                              load_s, step_s;
    logic [GI_W-1:0]                   gene_idx_s;
    logic [7:0]                        gene_s;
`ifdef GENETIC_MUTATION_EN
    logic [7:0]                        lfsr_q, lfsr_d;
`endif

    assign gene_idx_s = idx_q[GI_W-1:0];

    // Gene produced by crossover (and mutation, when built in) this cycle.
    always_comb begin
        if (gene_idx_s < HALF) begin
            gene_s = p1_q[gene_idx_s];
        end else begin
            gene_s = p2_q[gene_idx_s];
        end
`ifdef GENETIC_MUTATION_EN
        lfsr_d = lfsr_q;
        if (state_q == ST_MATE) begin
            lfsr_d = lfsr_next(lfsr_q);
            if (lfsr_q[3:0] == 4'd0) begin
                gene_s = MUT_BASE + {4'd0, lfsr_q[7:4]};
            end else begin
                gene_s = gene_s;
            end
        end else begin
            lfsr_d = lfsr_q;
        end
`endif
    end

    // Phase sequencing FSM with datapath next-state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        chrom_d     = chrom_q;
        target_d    = target_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        child_d     = child_q;
        fitness_d   = fitness_q;
        done_fit_d  = done_fit_q;
        done_mate_d = done_mate_q;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    chrom_d     = chromosome;
                    target_d    = target;
                    p1_d        = parent1;
                    p2_d        = parent2;
                    child_d     = '0;
                    fitness_d   = 5'd0;
                    done_fit_d  = 1'b0;
                    done_mate_d = 1'b0;
                    idx_d       = '0;
                    load_s      = 1'b1;
                    state_d     = ST_FIT;
                end else begin
                    state_d     = state_q;
                end
            end
            ST_FIT: begin
                if (chrom_q[gene_idx_s] == target_q[gene_idx_s]) begin
                    fitness_d = fitness_q + 5'd1;
                end else begin
                    fitness_d = fitness_q;
                end
                if (idx_q == LAST_GENE) begin
                    done_fit_d = 1'b1;
                    idx_d      = '0;
                    state_d    = ST_SORT;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                end
            end
            ST_SORT: begin
                step_s = 1'b1;
                if (idx_q == LAST_STEP) begin
                    idx_d   = '0;
                    state_d = ST_MATE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_MATE: begin
                child_d[gene_idx_s] = gene_s;
                if (idx_q == LAST_GENE) begin
                    done_mate_d = 1'b1;
                    idx_d       = '0;
                    state_d     = ST_DONE;
                end else begin
                    idx_d       = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, captured inputs and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            chrom_q     <= '0;
            target_q    <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            child_q     <= '0;
            fitness_q   <= 5'd0;
            done_fit_q  <= 1'b0;
            done_mate_q <= 1'b0;
`ifdef GENETIC_MUTATION_EN
            lfsr_q      <= LFSR_SEED;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            chrom_q     <= chrom_d;
            target_q    <= target_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            child_q     <= child_d;
            fitness_q   <= fitness_d;
            done_fit_q  <= done_fit_d;
            done_mate_q <= done_mate_d;
`ifdef GENETIC_MUTATION_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    ga_sorter #(
        .POP_SIZE (POP_SIZE),
        .WIDTH    (WIDTH)
    ) u_sorter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .step     (step_s),
        .data_in  (fitness_array),
        .data_out (sorted_array),
        .done     (done_sort)
    );

    assign fitness   = fitness_q;
    assign child     = child_q;
    assign done_fit  = done_fit_q;
    assign done_mate = done_mate_q;

endmodule

// File: tb/tb_genetic_top.sv
// Randomized bench for genetic_top with a behavioural reference model.
module tb_genetic_top;

    localparam int GL = 28;
    localparam int PS = 10;
    localparam int W  = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [GL-1:0][7:0]   chromosome, target, parent1, parent2;
    logic [PS-1:0][W-1:0] fitness_array;
    logic [4:0]           fitness;
    logic [PS-1:0][W-1:0] sorted_array;
    logic [GL-1:0][7:0]   child;
    logic                 done_fit, done_sort, done_mate;

    int total = 0;
    int bad   = 0;

    genetic_top #(.GENOME_LENGTH(GL), .POP_SIZE(PS), .WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .chromosome    (chromosome),
        .target        (target),
        .parent1       (parent1),
        .parent2       (parent2),
        .fitness_array (fitness_array),
        .fitness       (fitness),
        .sorted_array  (sorted_array),
        .child         (child),
        .done_fit      (done_fit),
        .done_sort     (done_sort),
        .done_mate     (done_mate)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < GL; i++) begin
            chromosome[i] = 8'($urandom_range(97, 99));
            target[i]     = 8'($urandom_range(97, 99));
            parent1[i]    = 8'($urandom_range(0, 255));
            parent2[i]    = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < PS; i++) begin
            fitness_array[i] = W'($urandom_range(0, (1 << W) - 1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_fit"},   256'(fitness), 256'(0));
        check_val({tag, "_sort"},  256'(sorted_array), 256'(0));
        check_val({tag, "_child"}, 256'(child), 256'(0));
        check_val({tag, "_flags"}, 256'({done_fit, done_sort, done_mate}), 256'(0));
    endtask

    // Launch a run from the current inputs, scramble inputs afterwards, and
    // compare against the model. mid_start>0 pulses start after that cycle.
    task automatic run_and_check(input string name, input int mid_start);
        int                   exp_fit;
        int                   pos;
        int                   t_fit, t_sort, t_mate;
        logic [PS-1:0][W-1:0] exp_sorted, got_sorted;
        logic [GL-1:0][7:0]   exp_child;
        logic [4:0]           got_fit;

        exp_fit = 0;
        for (int i = 0; i < GL; i++) begin
            if (chromosome[i] == target[i]) exp_fit++;
            exp_child[i] = (i < GL / 2) ? parent1[i] : parent2[i];
        end
        pos = 0;
        exp_sorted = '0;
        for (int v = (1 << W) - 1; v >= 0; v--) begin
            for (int i = 0; i < PS; i++) begin
                if (int'(fitness_array[i]) == v) begin
                    exp_sorted[pos] = W'(v);
                    pos++;
                end
            end
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({name, "_c0_flags"}, 256'({done_fit, done_sort, done_mate}), 256'(0));
        check_val({name, "_c0_fit"},   256'(fitness), 256'(0));
        check_val({name, "_c0_child"}, 256'(child), 256'(0));
        rand_inputs();

        t_fit = 0; t_sort = 0; t_mate = 0;
        got_fit = '0; got_sorted = '0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done_fit && t_fit == 0) begin
                t_fit   = k;
                got_fit = fitness;
            end
            if (done_sort && t_sort == 0) begin
                t_sort     = k;
                got_sorted = sorted_array;
            end
            if (done_mate && t_mate == 0) t_mate = k;
            start = (k == mid_start) ? 1'b1 : 1'b0;
            if (t_mate != 0) break;
        end
        start = 1'b0;

        check_val({name, "_t_fit"},  256'(t_fit),  256'(GL));
        check_val({name, "_t_sort"}, 256'(t_sort), 256'(GL + PS));
        check_val({name, "_t_mate"}, 256'(t_mate), 256'(2 * GL + PS));
        check_val({name, "_fitness"}, 256'(got_fit), 256'(exp_fit));
        check_val({name, "_sorted"},  256'(got_sorted), 256'(exp_sorted));
        check_val({name, "_child"},   256'(child), 256'(exp_child));
        @(negedge clk);
        check_val({name, "_sticky"}, 256'({done_fit, done_sort, done_mate}), 256'(3'b111));
        check_val({name, "_fit_hold"},  256'(fitness), 256'(exp_fit));
        check_val({name, "_sort_hold"}, 256'(sorted_array), 256'(exp_sorted));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rand_inputs();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Identical strings, ascending population, 'a'/'z' parents.
        rand_inputs();
        target = chromosome;
        for (int i = 0; i < PS; i++) fitness_array[i] = W'(i);
        for (int i = 0; i < GL; i++) begin
            parent1[i] = 8'd97;
            parent2[i] = 8'd122;
        end
        run_and_check("equal", 0);

        // Every gene differs, duplicates in population, start during MATE.
        rand_inputs();
        for (int i = 0; i < GL; i++) target[i] = chromosome[i] ^ 8'h80;
        fitness_array[0] = W'(3);
        fitness_array[1] = W'(3);
        fitness_array[2] = W'(7);
        fitness_array[3] = W'(0);
        run_and_check("differ", 50);

        for (int r = 0; r < 4; r++) begin
            rand_inputs();
            run_and_check($sformatf("rand%0d", r), (r == 2) ? 45 : 0);
        end

        // Reset while sorting aborts the run; a fresh run still completes.
        rand_inputs();
        target = chromosome;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        check_val("mid_sort_fit_done", 256'({done_fit, done_sort}), 256'(2'b10));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid_reset");
        @(negedge clk);
        check_all_zero("mid_reset_idle");

        rand_inputs();
        run_and_check("after_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
